// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - decode register file with WB bypass and pending-write scoreboard
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic            Rs1UseD,
    input  logic            Rs2UseD,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    input  logic            IssueD,
    input  logic [4:0]      IssueRdD,
    input  logic            CancelE,
    input  logic [4:0]      CancelRdE,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic            StallD,
    output logic            SbErr
);

    localparam logic [CNT_W:0] CNT_MAX = (CNT_W+1)'((2**CNT_W) - 1);

    logic [XLEN-1:0]  regs     [NREGS];
    logic [CNT_W-1:0] cnt      [NREGS];
    logic [CNT_W-1:0] cnt_next [NREGS];
    logic             pend     [NREGS];
    logic             err_any;

    // Architectural register writes from writeback; x0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else if (RegWriteW && RdW != 5'd0) begin
            regs[RdW] <= ResultW;
        end
    end

    // Per-register counter update (issue minus retire/cancel as a single step) and effective pending
    always_comb begin
        err_any = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            logic           inc;
            logic [1:0]     dec;
            logic [CNT_W:0] sum;
            logic [CNT_W:0] decx;
            logic [CNT_W:0] diff;
            inc  = 1'b0;
            dec  = 2'd0;
            sum  = '0;
            decx = '0;
            diff = '0;
            cnt_next[r] = '0;
            pend[r]     = 1'b0;
            if (r != 0) begin
                inc  = IssueD && (IssueRdD == 5'(r));
                dec  = {1'b0, RegWriteW && (RdW == 5'(r))} + {1'b0, CancelE && (CancelRdE == 5'(r))};
                sum  = {1'b0, cnt[r]} + {{CNT_W{1'b0}}, inc};
                decx = (CNT_W+1)'(dec);
                diff = sum - decx;
                // Same-cycle retire is already visible through the bypass, so it no longer blocks
                pend[r] = ({1'b0, cnt[r]} > decx);
                if (sum < decx) begin
                    cnt_next[r] = '0;
                    err_any     = 1'b1;
                end else if (diff > CNT_MAX) begin
                    cnt_next[r] = CNT_MAX[CNT_W-1:0];
                    err_any     = 1'b1;
                end else begin
                    cnt_next[r] = diff[CNT_W-1:0];
                end
            end
        end
    end

    // Scoreboard counters and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
            SbErr <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) cnt[r] <= cnt_next[r];
            SbErr <= SbErr | err_any;
        end
    end

    // Zero-latency read ports with writeback bypass; forced to zero while in reset
    always_comb begin
        if (!rst_n || Rs1D == 5'd0)           RD1D = '0;
        else if (RegWriteW && RdW == Rs1D)    RD1D = ResultW;
        else                                  RD1D = regs[Rs1D];
        if (!rst_n || Rs2D == 5'd0)           RD2D = '0;
        else if (RegWriteW && RdW == Rs2D)    RD2D = ResultW;
        else                                  RD2D = regs[Rs2D];
    end

    // Decode stall while a used source still has an outstanding write
    always_comb begin
        StallD = (Rs1UseD && Rs1D != 5'd0 && pend[Rs1D]) ||
                 (Rs2UseD && Rs2D != 5'd0 && pend[Rs2D]);
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard bench for regfile_scoreboard
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Rs1D, Rs2D, IssueRdD, CancelRdE, RdW;
    logic        Rs1UseD, Rs2UseD, IssueD, CancelE, RegWriteW;
    logic [31:0] ResultW;
    logic [31:0] RD1D, RD2D;
    logic        StallD, SbErr;

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1UseD(Rs1UseD), .Rs2UseD(Rs2UseD),
        .RD1D(RD1D), .RD2D(RD2D),
        .IssueD(IssueD), .IssueRdD(IssueRdD),
        .CancelE(CancelE), .CancelRdE(CancelRdE),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .StallD(StallD), .SbErr(SbErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        stall;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    logic chk = 1'b0;
    int   total = 0;
    int   bad = 0;

    // Monitor: compare DUT outputs against the oldest expectation mid-cycle
    always @(negedge clk) begin
        if (chk) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL queue_empty: monitor had no expectation");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (RD1D !== e.rd1) begin bad++; $display("FAIL %s rd1: got %h want %h", e.name, RD1D, e.rd1); end
                total++;
                if (RD2D !== e.rd2) begin bad++; $display("FAIL %s rd2: got %h want %h", e.name, RD2D, e.rd2); end
                total++;
                if (StallD !== e.stall) begin bad++; $display("FAIL %s stall: got %b want %b", e.name, StallD, e.stall); end
                total++;
                if (SbErr !== e.err) begin bad++; $display("FAIL %s sberr: got %b want %b", e.name, SbErr, e.err); end
            end
        end
    end

    task automatic clr();
        Rs1D = 0; Rs2D = 0; Rs1UseD = 0; Rs2UseD = 0;
        IssueD = 0; IssueRdD = 0; CancelE = 0; CancelRdE = 0;
        RegWriteW = 0; RdW = 0; ResultW = 0;
    endtask

    // Push the expectation for the inputs currently applied, let the monitor check, advance a cycle
    task automatic step(input string name, input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic stall, input logic err);
        exp_t e;
        e.name = name; e.rd1 = rd1; e.rd2 = rd2; e.stall = stall; e.err = err;
        exp_q.push_back(e);
        chk = 1'b1;
        @(posedge clk);
        #1;
        chk = 1'b0;
        clr();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        rst_n = 1'b0;
        @(posedge clk); #1;
        Rs1D = 5'd5; Rs1UseD = 1;
        step("in_reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        // 1: all registers read as zero after reset
        for (int i = 1; i < 32; i++) begin
            Rs1D = 5'(i); Rs2D = 5'(32 - i); Rs1UseD = 1; Rs2UseD = 1;
            step("reset_read", 0, 0, 0, 0);
        end
        // 2: writeback bypass then held value
        IssueD = 1; IssueRdD = 5;
        step("issue_x5", 0, 0, 0, 0);
        RegWriteW = 1; RdW = 5; ResultW = 32'hDEADBEEF; Rs1D = 5; Rs1UseD = 1;
        step("bypass_x5", 32'hDEADBEEF, 0, 0, 0);
        Rs1D = 5; Rs1UseD = 1; Rs2D = 5;
        step("held_x5", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        // 3: x0 writes, issues and cancels are ignored
        RegWriteW = 1; RdW = 0; ResultW = 32'h1234; Rs2D = 0; Rs1D = 5;
        step("wb_x0", 32'hDEADBEEF, 0, 0, 0);
        IssueD = 1; IssueRdD = 0; CancelE = 1; CancelRdE = 0; Rs1UseD = 1; Rs2UseD = 1;
        step("x0_sb_ignored", 0, 0, 0, 0);
        Rs1UseD = 1; Rs2UseD = 1;
        step("x0_read", 0, 0, 0, 0);
        // 4: stall until writeback, released in the retire cycle
        IssueD = 1; IssueRdD = 7;
        step("issue_x7", 0, 0, 0, 0);
        Rs1D = 7; Rs1UseD = 1;
        step("stall_x7", 0, 0, 1, 0);
        Rs1D = 7; Rs1UseD = 1; RegWriteW = 1; RdW = 7; ResultW = 32'h55;
        step("retire_x7", 32'h55, 0, 0, 0);
        Rs1D = 7; Rs1UseD = 1;
        step("after_x7", 32'h55, 0, 0, 0);
        // Use flags gate the stall; cancel releases it
        IssueD = 1; IssueRdD = 8;
        step("issue_x8", 0, 0, 0, 0);
        Rs2D = 8;
        step("x8_unused", 0, 0, 0, 0);
        Rs2D = 8; Rs2UseD = 1;
        step("x8_used", 0, 0, 1, 0);
        Rs2D = 8; Rs2UseD = 1; CancelE = 1; CancelRdE = 8;
        step("cancel_x8", 0, 0, 0, 0);
        Rs2D = 8; Rs2UseD = 1;
        step("after_cancel_x8", 0, 0, 0, 0);
        // Same-cycle issue does not stall until the next cycle
        IssueD = 1; IssueRdD = 10; Rs1D = 10; Rs1UseD = 1;
        step("issue_x10_same", 0, 0, 0, 0);
        Rs1D = 10; Rs1UseD = 1;
        step("stall_x10", 0, 0, 1, 0);
        Rs1D = 10; Rs1UseD = 1; RegWriteW = 1; RdW = 10; ResultW = 32'hA;
        step("retire_x10", 32'hA, 0, 0, 0);
        // 6a: issue and cancel of the same register in one cycle leaves the count unchanged
        IssueD = 1; IssueRdD = 9; CancelE = 1; CancelRdE = 9;
        step("issue_cancel_x9", 0, 0, 0, 0);
        Rs1D = 9; Rs1UseD = 1;
        step("after_x9", 0, 0, 0, 0);
        // 5: saturation at three in-flight writes
        for (int i = 0; i < 3; i++) begin
            IssueD = 1; IssueRdD = 3;
            step("issue_x3", 0, 0, 0, 0);
        end
        Rs1D = 3; Rs1UseD = 1;
        step("stall_x3", 0, 0, 1, 0);
        IssueD = 1; IssueRdD = 3;
        step("overflow_x3", 0, 0, 0, 0);
        Rs1D = 3; Rs1UseD = 1;
        step("err_x3", 0, 0, 1, 1);
        Rs1D = 3; Rs1UseD = 1; RegWriteW = 1; RdW = 3; ResultW = 32'h31;
        step("wb1_x3", 32'h31, 0, 1, 1);
        Rs1D = 3; Rs1UseD = 1; RegWriteW = 1; RdW = 3; ResultW = 32'h32;
        step("wb2_x3", 32'h32, 0, 1, 1);
        Rs1D = 3; Rs1UseD = 1; RegWriteW = 1; RdW = 3; ResultW = 32'h33;
        step("wb3_x3", 32'h33, 0, 0, 1);
        Rs1D = 3; Rs1UseD = 1;
        step("drained_x3", 32'h33, 0, 0, 1);
        // 6b: asynchronous reset mid-run clears everything
        IssueD = 1; IssueRdD = 12;
        step("issue_x12", 0, 0, 0, 1);
        rst_n = 1'b0;
        Rs1D = 5; Rs2D = 12; Rs2UseD = 1;
        step("rst_regs", 0, 0, 0, 0);
        RegWriteW = 1; RdW = 6; ResultW = 32'hFFFF; Rs1D = 6;
        step("rst_bypass", 0, 0, 0, 0);
        rst_n = 1'b1;
        Rs1D = 5; Rs2D = 12; Rs2UseD = 1;
        step("post_rst", 0, 0, 0, 0);
        // Underflow: writeback with no pending issue still writes but flags the error
        RegWriteW = 1; RdW = 4; ResultW = 32'h44; Rs1D = 4;
        step("underflow_x4", 32'h44, 0, 0, 0);
        Rs1D = 4; Rs1UseD = 1;
        step("underflow_err", 32'h44, 0, 0, 1);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
